score_counter: RTL and testbench

- Consumer end of the pushbutton event interface: takes the short-press (count_up) and long-press (count_down) event lines from the pushbutton processor and keeps a two-digit BCD score.
- Drives a multiplexed two-digit 7-segment display.
- Runs on the same 1 kHz system clock; sits between the pushbutton processor and the board display pins.

---
 rtl/score_counter.sv | 154 +++++++++++++++
 tb/tb_score_counter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_counter.sv
// score_counter
//   Two-digit BCD up/down score counter driven by pushbutton event levels,
//   with a multiplexed two-digit 7-segment display driver.
//
// Ports:
//   clk_1khz      system clock (1 kHz)
//   rst_i         asynchronous reset, active low
//   count_up_i    short-press level; each rising level adds one
//   count_down_i  long-press level; each rising level subtracts one
//   score_o       packed BCD score, [7:4] tens, [3:0] ones
//   change_o      one-cycle pulse after an edge that changed the score
//   seg_o         active-high segments, bit order gfedcba
//   digit_sel_o   one-hot digit enable: 2'b01 ones, 2'b10 tens
module score_counter #(
    parameter int unsigned MUX_PERIOD = 5,
    parameter int unsigned MAX_SCORE  = 99,
    parameter bit          SATURATE   = 1'b1,
    parameter bit          BLANK_LZ   = 1'b1
) (
    input  logic       clk_1khz,
    input  logic       rst_i,
    input  logic       count_up_i,
    input  logic       count_down_i,
    output logic [7:0] score_o,
    output logic       change_o,
    output logic [6:0] seg_o,
    output logic [1:0] digit_sel_o
);

    localparam int unsigned      CNT_W    = (MUX_PERIOD > 1) ? $clog2(MUX_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUX_PERIOD - 1);
    localparam logic [3:0]       MAX_T    = 4'(MAX_SCORE / 10);
    localparam logic [3:0]       MAX_O    = 4'(MAX_SCORE % 10);

    typedef enum logic [1:0] {
        DIG_ONES = 2'b01,
        DIG_TENS = 2'b10
    } digit_e;

    logic             up_q, up_d;
    logic             down_q, down_d;
    logic             armed_q, armed_d;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       ones_q, ones_d;
    logic             change_q, change_d;
    logic [CNT_W-1:0] mux_cnt_q, mux_cnt_d;
    digit_e           digit_q, digit_d;
    logic [6:0]       seg_q, seg_d;
    logic             up_ev, down_ev;
    logic [3:0]       show;

    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        case (d)
            4'd0:    seg_enc = 7'h3F;
            4'd1:    seg_enc = 7'h06;
            4'd2:    seg_enc = 7'h5B;
            4'd3:    seg_enc = 7'h4F;
            4'd4:    seg_enc = 7'h66;
            4'd5:    seg_enc = 7'h6D;
            4'd6:    seg_enc = 7'h7D;
            4'd7:    seg_enc = 7'h07;
            4'd8:    seg_enc = 7'h7F;
            4'd9:    seg_enc = 7'h6F;
            default: seg_enc = 7'h00;
        endcase
    endfunction

    always_comb begin
        up_d    = count_up_i;
        down_d  = count_down_i;
        armed_d = 1'b1;

        // History flops reset to 0, so the first edge after reset release
        // only loads them; armed_q masks that edge so a level held through
        // reset is not taken as a new press.
        up_ev   = count_up_i   & ~up_q   & armed_q;
        down_ev = count_down_i & ~down_q & armed_q;

        tens_d = tens_q;
        ones_d = ones_q;
        if (up_ev && !down_ev) begin
            if (tens_q == MAX_T && ones_q == MAX_O) begin
                if (!SATURATE) begin
                    tens_d = '0;
                    ones_d = '0;
                end
            end else if (ones_q == 4'd9) begin
                ones_d = '0;
                tens_d = tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end else if (down_ev && !up_ev) begin
            if (tens_q == 4'd0 && ones_q == 4'd0) begin
                if (!SATURATE) begin
                    tens_d = MAX_T;
                    ones_d = MAX_O;
                end
            end else if (ones_q == 4'd0) begin
                ones_d = 4'd9;
                tens_d = tens_q - 4'd1;
            end else begin
                ones_d = ones_q - 4'd1;
            end
        end
        change_d = ({tens_d, ones_d} != {tens_q, ones_q});

        if (mux_cnt_q == CNT_LAST) begin
            mux_cnt_d = '0;
            digit_d   = (digit_q == DIG_ONES) ? DIG_TENS : DIG_ONES;
        end else begin
            mux_cnt_d = mux_cnt_q + CNT_W'(1);
            digit_d   = digit_q;
        end

        // Segments follow the next digit and next score so they stay
        // paired with digit_sel_o and pick up a score change immediately.
        show  = (digit_d == DIG_TENS) ? tens_d : ones_d;
        seg_d = seg_enc(show);
        if (digit_d == DIG_TENS && tens_d == 4'd0 && BLANK_LZ) begin
            seg_d = '0;
        end
    end

    always_ff @(posedge clk_1khz or negedge rst_i) begin
        if (!rst_i) begin
            up_q      <= 1'b0;
            down_q    <= 1'b0;
            armed_q   <= 1'b0;
            tens_q    <= '0;
            ones_q    <= '0;
            change_q  <= 1'b0;
            mux_cnt_q <= '0;
            digit_q   <= DIG_ONES;
            seg_q     <= 7'h3F;
        end else begin
            up_q      <= up_d;
            down_q    <= down_d;
            armed_q   <= armed_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            change_q  <= change_d;
            mux_cnt_q <= mux_cnt_d;
            digit_q   <= digit_d;
            seg_q     <= seg_d;
        end
    end

    assign score_o     = {tens_q, ones_q};
    assign change_o    = change_q;
    assign seg_o       = seg_q;
    assign digit_sel_o = digit_q;

endmodule

// File: tb/tb_score_counter.sv
// Testbench for score_counter: two instances (saturating/blanking with a
// 5-cycle mux, wrapping/non-blanking with a 3-cycle mux) share stimulus and
// are compared every cycle against an integer-level reference model.
module tb_score_counter;

    logic       clk_1khz = 1'b0;
    logic       rst_i    = 1'b0;
    logic       count_up_i   = 1'b0;
    logic       count_down_i = 1'b0;

    logic [7:0] score_a, score_b;
    logic       change_a, change_b;
    logic [6:0] seg_a, seg_b;
    logic [1:0] dsel_a, dsel_b;

    always #5 clk_1khz = ~clk_1khz;

    score_counter #(
        .MUX_PERIOD(5),
        .MAX_SCORE (99),
        .SATURATE  (1'b1),
        .BLANK_LZ  (1'b1)
    ) dut_a (
        .clk_1khz    (clk_1khz),
        .rst_i       (rst_i),
        .count_up_i  (count_up_i),
        .count_down_i(count_down_i),
        .score_o     (score_a),
        .change_o    (change_a),
        .seg_o       (seg_a),
        .digit_sel_o (dsel_a)
    );

    score_counter #(
        .MUX_PERIOD(3),
        .MAX_SCORE (99),
        .SATURATE  (1'b0),
        .BLANK_LZ  (1'b0)
    ) dut_b (
        .clk_1khz    (clk_1khz),
        .rst_i       (rst_i),
        .count_up_i  (count_up_i),
        .count_down_i(count_down_i),
        .score_o     (score_b),
        .change_o    (change_b),
        .seg_o       (seg_b),
        .digit_sel_o (dsel_b)
    );

    // ---------------- reference model ----------------
    int unsigned m_s   [2];
    bit          m_chg [2];
    int unsigned m_k;
    bit          m_pu, m_pd, m_armed;
    int unsigned mux_p [2] = '{5, 3};
    bit          sat_p [2] = '{1'b1, 1'b0};
    bit          blk_p [2] = '{1'b1, 1'b0};
    logic [6:0]  enc   [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_s[i]   = 0;
            m_chg[i] = 1'b0;
        end
        m_k = 0; m_pu = 1'b0; m_pd = 1'b0; m_armed = 1'b0;
    endtask

    task automatic model_edge();
        bit ue, de;
        int unsigned old;
        if (!m_armed) begin
            ue = 1'b0; de = 1'b0; m_armed = 1'b1;
        end else begin
            ue = count_up_i && !m_pu;
            de = count_down_i && !m_pd;
        end
        m_pu = count_up_i;
        m_pd = count_down_i;
        for (int i = 0; i < 2; i++) begin
            old = m_s[i];
            if (ue && !de)
                m_s[i] = (m_s[i] == 99) ? (sat_p[i] ? 99 : 0) : m_s[i] + 1;
            else if (de && !ue)
                m_s[i] = (m_s[i] == 0) ? (sat_p[i] ? 0 : 99) : m_s[i] - 1;
            m_chg[i] = (m_s[i] != old);
        end
        m_k++;
    endtask

    function automatic logic [7:0] exp_score(input int i);
        exp_score = 8'(((m_s[i] / 10) << 4) | (m_s[i] % 10));
    endfunction

    function automatic logic [1:0] exp_dsel(input int i);
        exp_dsel = (((m_k / mux_p[i]) % 2) == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [6:0] exp_seg(input int i);
        int unsigned t;
        t = m_s[i] / 10;
        if (exp_dsel(i) == 2'b10)
            exp_seg = (t == 0 && blk_p[i]) ? 7'h00 : enc[t];
        else
            exp_seg = enc[m_s[i] % 10];
    endfunction

    task automatic check_all();
        chk("a score",  score_a,  exp_score(0));
        chk("a change", change_a, m_chg[0]);
        chk("a dsel",   dsel_a,   exp_dsel(0));
        chk("a seg",    seg_a,    exp_seg(0));
        chk("b score",  score_b,  exp_score(1));
        chk("b change", change_b, m_chg[1]);
        chk("b dsel",   dsel_b,   exp_dsel(1));
        chk("b seg",    seg_b,    exp_seg(1));
    endtask

    // Called at a negedge: drive inputs, step one edge, check at next negedge.
    task automatic cycle(input bit u, input bit d);
        count_up_i   = u;
        count_down_i = d;
        @(posedge clk_1khz);
        model_edge();
        @(negedge clk_1khz);
        check_all();
    endtask

    task automatic do_reset(input int n);
        rst_i = 1'b0;
        count_up_i = 1'b0;
        count_down_i = 1'b0;
        model_reset();
        repeat (n) begin
            @(negedge clk_1khz);
            check_all();
        end
        rst_i = 1'b1;
    endtask

    task automatic pulse_up();
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
    endtask

    task automatic set_score(input int n);
        do_reset(2);
        cycle(1'b0, 1'b0);
        repeat (n) pulse_up();
    endtask

    typedef struct {
        bit         up;
        bit         dn;
        logic [7:0] exp_score;
        bit         exp_chg;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 8'h01, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 8'h01, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 8'h01, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 8'h01, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 8'h01, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 8'h01, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 8'h00, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 8'h00, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 8'h00, 1'b0};

        @(negedge clk_1khz);

        // Reset defaults, then three spaced pulses.
        do_reset(5);
        cycle(1'b0, 1'b0);
        repeat (3) begin
            cycle(1'b1, 1'b0);
            chk("pulse change", change_a, 1'b1);
            repeat (9) cycle(1'b0, 1'b0);
        end
        chk("three pulses", score_a, 8'h03);

        // Table vectors: hold, cancel, saturation at zero.
        do_reset(2);
        cycle(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].up, vecs[i].dn);
            chk("vec score",  score_a,  vecs[i].exp_score);
            chk("vec change", change_a, vecs[i].exp_chg);
        end

        // Long hold counts once.
        do_reset(2);
        cycle(1'b0, 1'b0);
        repeat (2100) cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        chk("hold once", score_a, 8'h01);

        // Simultaneous rise at 05.
        set_score(5);
        cycle(1'b1, 1'b1);
        chk("simul score", score_a, 8'h05);
        chk("simul change", change_a, 1'b0);
        cycle(1'b0, 1'b1);
        chk("simul drop", score_a, 8'h05);
        cycle(1'b0, 1'b0);

        // BCD carry and borrow.
        set_score(9);
        cycle(1'b1, 1'b0);
        chk("carry 09->10", score_a, 8'h10);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        chk("borrow 10->09", score_a, 8'h09);
        cycle(1'b0, 1'b0);
        repeat (10) pulse_up();
        chk("at 19", score_a, 8'h19);
        cycle(1'b1, 1'b0);
        chk("carry 19->20", score_a, 8'h20);
        cycle(1'b0, 1'b0);

        // Upper bound: saturate vs wrap.
        set_score(99);
        chk("a at 99", score_a, 8'h99);
        cycle(1'b1, 1'b0);
        chk("a sat 99", score_a, 8'h99);
        chk("a sat no change", change_a, 1'b0);
        chk("b wrap to 00", score_b, 8'h00);
        chk("b wrap change", change_b, 1'b1);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        chk("a 99->98", score_a, 8'h98);
        chk("b wrap to 99", score_b, 8'h99);
        chk("b wrap down change", change_b, 1'b1);
        cycle(1'b0, 1'b0);

        // Display mux at 42 and leading-zero blanking at 07.
        set_score(42);
        repeat (20) cycle(1'b0, 1'b0);
        set_score(7);
        repeat (20) cycle(1'b0, 1'b0);

        // Asynchronous reset between edges, then release with up held high.
        set_score(37);
        cycle(1'b0, 1'b0);
        #2;
        rst_i = 1'b0;
        model_reset();
        #1;
        chk("async score",  score_a,  8'h00);
        chk("async change", change_a, 1'b0);
        chk("async dsel",   dsel_a,   2'b01);
        chk("async seg",    seg_a,    7'h3F);
        chk("async b score", score_b, 8'h00);
        count_up_i = 1'b1;
        @(negedge clk_1khz);
        check_all();
        rst_i = 1'b1;
        repeat (5) cycle(1'b1, 1'b0);
        chk("held through reset", score_a, 8'h00);
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        chk("re-press after reset", score_a, 8'h01);

        // Randomized run against the model.
        do_reset(2);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset(1);
            end
            cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
